// File: rtl/multi_ball_ctrl.sv
// multi_ball_ctrl
//   Motion engine for NBALL independent balls. Each ball has a position,
//   a direction, sub-pixel speed accumulators and an alive flag. All balls
//   advance together on the shared movement tick.
// Ports
//   clock, reset        : system clock, synchronous active-high reset
//   tick                : movement strobe; ball state advances only when high
//   floor               : 1 = bottom edge bounces, 0 = bottom edge kills
//   radius              : ball radius used for the wall tests
//   ld, ld_idx, ld_*    : load position/speed/direction into ball ld_idx
//   bd_valid/paddle/di  : per-ball collision report (di: 0 UP,1 RIGHT,2 DOWN,3 LEFT)
//   x_flat, y_flat      : ball i position at [i*XW +: XW]
//   alive, dead_pulse   : ball in play / one-cycle death strobe
//   all_dead            : no ball in play
module multi_ball_ctrl #(
   parameter int NBALL   = 3,
   parameter int XW      = 10,
   parameter int ACC_W   = 4,
   parameter int LEFT    = 16,
   parameter int TOP     = 16,
   parameter int MAXX    = 480,
   parameter int MAXY    = 448,
   parameter int SPD_MAX = 12
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  tick,
   input  logic                  floor,
   input  logic [5:0]            radius,
   input  logic                  ld,
   input  logic [2:0]            ld_idx,
   input  logic [XW-1:0]         ld_x,
   input  logic [XW-1:0]         ld_y,
   input  logic [ACC_W-1:0]      ld_sx,
   input  logic [ACC_W-1:0]      ld_sy,
   input  logic                  ld_dx,
   input  logic                  ld_dy,
   input  logic [NBALL-1:0]      bd_valid,
   input  logic [NBALL-1:0]      bd_paddle,
   input  logic [2*NBALL-1:0]    bd_di,
   output logic [NBALL*XW-1:0]   x_flat,
   output logic [NBALL*XW-1:0]   y_flat,
   output logic [NBALL-1:0]      alive,
   output logic [NBALL-1:0]      dead_pulse,
   output logic                  all_dead
);

   // Edge tests run one bit wider than the coordinates so that
   // position + radius can never wrap.
   localparam int EW = XW + 1;
   localparam logic [EW-1:0]    X_LO    = EW'(LEFT);
   localparam logic [EW-1:0]    X_HI    = EW'(LEFT + MAXX);
   localparam logic [EW-1:0]    Y_LO    = EW'(TOP);
   localparam logic [EW-1:0]    Y_HI    = EW'(TOP + MAXY);
   localparam logic [ACC_W-1:0] SPD_SAT = ACC_W'(SPD_MAX);
   localparam logic [ACC_W-1:0] ONE     = ACC_W'(1);
   localparam logic [XW-1:0]    CMAX    = '1;

   logic [EW-1:0] rad_e;
   assign rad_e = EW'(radius);

   for (genvar i = 0; i < NBALL; i++) begin : g_ball
      logic [XW-1:0]    x_q, x_d, y_q, y_d;
      logic             dx_q, dx_d, dy_q, dy_d;
      logic [ACC_W-1:0] sx_q, sx_d, sy_q, sy_d, ax_q, ax_d, ay_q, ay_d;
      logic             al_q, al_d, dp_q, dp_d;
      logic             hit_ld, pad_up;
      logic [1:0]       di;
      logic [ACC_W:0]   sumx, sumy;
      logic [EW-1:0]    xe, ye;

      assign hit_ld = ld && (32'(ld_idx) == i);
      assign di     = bd_di[2*i +: 2];
      assign pad_up = bd_valid[i] && bd_paddle[i] && (di == 2'd0);
      assign sumx   = {1'b0, ax_q} + {1'b0, sx_q};
      assign sumy   = {1'b0, ay_q} + {1'b0, sy_q};
      assign xe     = {1'b0, x_q};
      assign ye     = {1'b0, y_q};

      always_comb begin
         x_d  = x_q;  y_d  = y_q;
         dx_d = dx_q; dy_d = dy_q;
         sx_d = sx_q; sy_d = sy_q;
         ax_d = ax_q; ay_d = ay_q;
         al_d = al_q; dp_d = 1'b0;
         if (hit_ld) begin
            x_d  = ld_x;  y_d  = ld_y;
            dx_d = ld_dx; dy_d = ld_dy;
            sx_d = (ld_sx == '0) ? ONE : ld_sx;
            sy_d = (ld_sy == '0) ? ONE : ld_sy;
            ax_d = '0;    ay_d = '0;
            al_d = 1'b1;
         end else if (tick && al_q) begin
            if (bd_valid[i]) begin
               case (di)
                  2'd0:    dy_d = 1'b1;
                  2'd1:    dx_d = 1'b0;
                  2'd2:    dy_d = 1'b0;
                  default: dx_d = 1'b1;
               endcase
            end
            // walls have the last word on direction
            if (xe <= X_LO + rad_e)        dx_d = 1'b0;
            else if (xe + rad_e >= X_HI)   dx_d = 1'b1;
            if (ye < Y_LO + rad_e)         dy_d = 1'b0;
            else if (floor && (ye + rad_e >= Y_HI)) dy_d = 1'b1;
            // sub-pixel move; coordinates clamp instead of wrapping
            ax_d = sumx[ACC_W-1:0];
            ay_d = sumy[ACC_W-1:0];
            if (sumx[ACC_W]) begin
               if (dx_d) x_d = (x_q == '0)  ? x_q : x_q - 1'b1;
               else      x_d = (x_q == CMAX) ? x_q : x_q + 1'b1;
            end
            if (sumy[ACC_W]) begin
               if (dy_d) y_d = (y_q == '0)  ? y_q : y_q - 1'b1;
               else      y_d = (y_q == CMAX) ? y_q : y_q + 1'b1;
            end
            if (pad_up) begin
               sx_d = (sx_q >= SPD_SAT) ? SPD_SAT : sx_q + ONE;
               sy_d = (sy_q >= SPD_SAT) ? SPD_SAT : sy_q + ONE;
            end
            if (!floor && ({1'b0, y_d} >= Y_HI)) begin
               al_d = 1'b0;
               dp_d = 1'b1;
            end
         end
      end

      always_ff @(posedge clock) begin
         if (reset) begin
            x_q  <= XW'(LEFT + MAXX);
            y_q  <= XW'(TOP + MAXY);
            dx_q <= 1'b0; dy_q <= 1'b0;
            sx_q <= ONE;  sy_q <= ONE;
            ax_q <= '0;   ay_q <= '0;
            al_q <= 1'b0; dp_q <= 1'b0;
         end else begin
            x_q  <= x_d;  y_q  <= y_d;
            dx_q <= dx_d; dy_q <= dy_d;
            sx_q <= sx_d; sy_q <= sy_d;
            ax_q <= ax_d; ay_q <= ay_d;
            al_q <= al_d; dp_q <= dp_d;
         end
      end

      assign x_flat[i*XW +: XW] = x_q;
      assign y_flat[i*XW +: XW] = y_q;
      assign alive[i]           = al_q;
      assign dead_pulse[i]      = dp_q;
   end

   assign all_dead = ~|alive;

endmodule

// File: tb/tb_multi_ball_ctrl.sv
module tb_multi_ball_ctrl;
   localparam int NB = 3;
   localparam int LEFT = 16, TOP = 16, MAXX = 480, MAXY = 448, SPD_MAX = 12;

   logic clock = 1'b0;
   logic reset, tick, floor, ld, ld_dx, ld_dy;
   logic [5:0]  radius;
   logic [2:0]  ld_idx;
   logic [9:0]  ld_x, ld_y;
   logic [3:0]  ld_sx, ld_sy;
   logic [NB-1:0]   bd_valid, bd_paddle;
   logic [2*NB-1:0] bd_di;
   logic [NB*10-1:0] x_flat, y_flat;
   logic [NB-1:0]   alive, dead_pulse;
   logic            all_dead;

   multi_ball_ctrl dut (
      .clock(clock), .reset(reset), .tick(tick), .floor(floor), .radius(radius),
      .ld(ld), .ld_idx(ld_idx), .ld_x(ld_x), .ld_y(ld_y), .ld_sx(ld_sx), .ld_sy(ld_sy),
      .ld_dx(ld_dx), .ld_dy(ld_dy), .bd_valid(bd_valid), .bd_paddle(bd_paddle),
      .bd_di(bd_di), .x_flat(x_flat), .y_flat(y_flat), .alive(alive),
      .dead_pulse(dead_pulse), .all_dead(all_dead));

   always #5 clock = ~clock;

   int checks = 0, passes = 0;

   // reference model: plain integers, direction as +1/-1 velocity sign
   int mx[NB], my[NB], vx[NB], vy[NB], msx[NB], msy[NB], ax[NB], ay[NB];
   bit mal[NB], mdp[NB];

   function automatic int clampc(input int v);
      return (v < 0) ? 0 : (v > 1023) ? 1023 : v;
   endfunction

   function automatic int minv(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic model_update();
      for (int i = 0; i < NB; i++) begin
         if (reset) begin
            mx[i] = LEFT + MAXX; my[i] = TOP + MAXY; vx[i] = 1; vy[i] = 1;
            msx[i] = 1; msy[i] = 1; ax[i] = 0; ay[i] = 0; mal[i] = 0; mdp[i] = 0;
            continue;
         end
         mdp[i] = 0;
         if (ld && int'(ld_idx) == i) begin
            mx[i] = ld_x; my[i] = ld_y;
            vx[i] = ld_dx ? -1 : 1; vy[i] = ld_dy ? -1 : 1;
            msx[i] = (ld_sx == 0) ? 1 : int'(ld_sx);
            msy[i] = (ld_sy == 0) ? 1 : int'(ld_sy);
            ax[i] = 0; ay[i] = 0; mal[i] = 1;
         end else if (tick && mal[i]) begin
            int r, d;
            r = radius;
            if (bd_valid[i]) begin
               d = bd_di[2*i +: 2];
               if (d == 0) vy[i] = -1;
               if (d == 2) vy[i] = 1;
               if (d == 1) vx[i] = 1;
               if (d == 3) vx[i] = -1;
            end
            if (mx[i] <= LEFT + r) vx[i] = 1;
            else if (mx[i] + r >= LEFT + MAXX) vx[i] = -1;
            if (my[i] < TOP + r) vy[i] = 1;
            else if (floor && my[i] + r >= TOP + MAXY) vy[i] = -1;
            ax[i] += msx[i]; ay[i] += msy[i];
            if (ax[i] >= 16) begin ax[i] -= 16; mx[i] = clampc(mx[i] + vx[i]); end
            if (ay[i] >= 16) begin ay[i] -= 16; my[i] = clampc(my[i] + vy[i]); end
            if (bd_valid[i] && bd_paddle[i] && bd_di[2*i +: 2] == 2'd0) begin
               msx[i] = minv(msx[i] + 1, SPD_MAX);
               msy[i] = minv(msy[i] + 1, SPD_MAX);
            end
            if (!floor && my[i] >= TOP + MAXY) begin mal[i] = 0; mdp[i] = 1; end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic compare_all();
      logic [NB-1:0] eal, edp;
      for (int i = 0; i < NB; i++) begin
         chk($sformatf("x%0d", i), 32'(x_flat[i*10 +: 10]), mx[i]);
         chk($sformatf("y%0d", i), 32'(y_flat[i*10 +: 10]), my[i]);
         eal[i] = mal[i]; edp[i] = mdp[i];
      end
      chk("alive", 32'(alive), 32'(eal));
      chk("dead_pulse", 32'(dead_pulse), 32'(edp));
      chk("all_dead", 32'(all_dead), 32'(eal == '0));
   endtask

   task automatic step();
      model_update();
      @(posedge clock);
      #1;
      compare_all();
   endtask

   task automatic load(input int idx, input int x, input int y, input int sx, input int sy,
                       input bit dx, input bit dy);
      ld = 1; ld_idx = 3'(idx); ld_x = 10'(x); ld_y = 10'(y);
      ld_sx = 4'(sx); ld_sy = 4'(sy); ld_dx = dx; ld_dy = dy;
   endtask

   int exp_x1[6] = '{21, 20, 21, 22, 23, 24};

   initial begin
      reset = 1; tick = 0; floor = 1; radius = 6'd4; ld = 0; ld_idx = 0;
      ld_x = 0; ld_y = 0; ld_sx = 0; ld_sy = 0; ld_dx = 0; ld_dy = 0;
      bd_valid = 0; bd_paddle = 0; bd_di = 0;
      #2;
      step();
      chk("rst_x0", 32'(x_flat[9:0]), 496);
      chk("rst_y0", 32'(y_flat[9:0]), 464);
      chk("rst_all_dead", 32'(all_dead), 1);
      reset = 0; step();

      // straight-line motion: sx=8 -> 16 px, sy=4 -> 8 px in 32 ticks
      load(0, 100, 100, 8, 4, 0, 0); step(); ld = 0;
      tick = 1;
      repeat (32) step();
      chk("lin_x0", 32'(x_flat[9:0]), 116);
      chk("lin_y0", 32'(y_flat[9:0]), 108);
      chk("lin_alive", 32'(alive), 1);

      // left wall bounce at LEFT+radius = 20
      tick = 0; load(1, 21, 200, 15, 1, 1, 0); step(); ld = 0; tick = 1;
      for (int k = 0; k < 6; k++) begin
         step();
         chk($sformatf("wall_x1_t%0d", k + 1), 32'(x_flat[19:10]), exp_x1[k]);
      end

      // floor kill
      floor = 0; tick = 0; load(2, 200, 463, 1, 15, 0, 0); step(); ld = 0; tick = 1;
      step();
      chk("kill_y2_pre", 32'(y_flat[29:20]), 463);
      step();
      chk("kill_y2", 32'(y_flat[29:20]), 464);
      chk("kill_pulse", 32'(dead_pulse[2]), 1);
      chk("kill_alive2", 32'(alive[2]), 0);
      step();
      chk("kill_pulse_off", 32'(dead_pulse[2]), 0);
      repeat (3) step();
      chk("kill_frozen", 32'(y_flat[29:20]), 464);
      floor = 1;

      // paddle speed-up with saturation
      tick = 0; load(0, 200, 200, 11, 11, 0, 0); step(); ld = 0; tick = 1;
      bd_valid = 3'b001; bd_paddle = 3'b001; bd_di = 6'b000000;
      repeat (3) step();
      chk("pad_x0", 32'(x_flat[9:0]), 202);
      chk("pad_y0", 32'(y_flat[9:0]), 198);
      bd_valid = 0; bd_paddle = 0;
      repeat (8) step();

      // right wall overrides a RIGHT collision
      tick = 0; load(1, 492, 300, 15, 1, 0, 0); step(); ld = 0; tick = 1;
      bd_valid = 3'b010; bd_di = 6'b000100;
      repeat (2) step();
      chk("wallwin_x1", 32'(x_flat[19:10]), 491);
      bd_valid = 0; bd_di = 0;

      // load during tick does not stall other balls
      load(0, 300, 300, 5, 5, 0, 1); step(); ld = 0;
      chk("ldtick_x0", 32'(x_flat[9:0]), 300);
      step();

      // reset wins over load and tick
      reset = 1; load(1, 100, 100, 3, 3, 0, 0); step();
      chk("midrst_all_dead", 32'(all_dead), 1);
      reset = 0; ld = 0; step();

      // randomized phase
      for (int c = 0; c < 1500; c++) begin
         reset = ($urandom_range(199, 0) == 0);
         tick  = ($urandom_range(9, 0) < 7);
         if ($urandom_range(49, 0) == 0) floor = ~floor;
         if ($urandom_range(29, 0) == 0) radius = 6'($urandom_range(15, 0));
         ld = ($urandom_range(9, 0) == 0);
         ld_idx = 3'($urandom_range(7, 0));
         ld_x = 10'($urandom_range(LEFT + MAXX - 1, LEFT));
         ld_y = 10'($urandom_range(TOP + MAXY - 1, TOP));
         ld_sx = 4'($urandom); ld_sy = 4'($urandom);
         ld_dx = 1'($urandom); ld_dy = 1'($urandom);
         bd_valid = NB'($urandom); bd_paddle = NB'($urandom); bd_di = (2*NB)'($urandom);
         step();
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
